// File: rtl/dual_issue_scoreboard_if.sv
// Issue-slot bundle between decode (master) and the dual-issue hazard scoreboard (slave).
interface dual_issue_scoreboard_if #(
  parameter int IDX_W = 7,
  parameter int LAT_W = 3
);
  logic             valid_1;
  logic [IDX_W-1:0] ra_1;
  logic [IDX_W-1:0] rb_1;
  logic [IDX_W-1:0] rc_1;
  logic             useRA_1;
  logic             useRB_1;
  logic             useRC_1;
  logic [IDX_W-1:0] rt_1;
  logic             writesRT_1;
  logic [LAT_W-1:0] lat_1;

  logic             valid_2;
  logic [IDX_W-1:0] ra_2;
  logic [IDX_W-1:0] rb_2;
  logic [IDX_W-1:0] rc_2;
  logic             useRA_2;
  logic             useRB_2;
  logic             useRC_2;
  logic [IDX_W-1:0] rt_2;
  logic             writesRT_2;
  logic [LAT_W-1:0] lat_2;

  logic             issue_1;
  logic             issue_2;
  logic             stall;

  modport master (
    output valid_1, ra_1, rb_1, rc_1, useRA_1, useRB_1, useRC_1, rt_1, writesRT_1, lat_1,
    output valid_2, ra_2, rb_2, rc_2, useRA_2, useRB_2, useRC_2, rt_2, writesRT_2, lat_2,
    input  issue_1, issue_2, stall
  );

  modport slave (
    input  valid_1, ra_1, rb_1, rc_1, useRA_1, useRB_1, useRC_1, rt_1, writesRT_1, lat_1,
    input  valid_2, ra_2, rb_2, rc_2, useRA_2, useRB_2, useRC_2, rt_2, writesRT_2, lat_2,
    output issue_1, issue_2, stall
  );
endinterface

// File: rtl/dual_issue_scoreboard.sv
// Dual-issue RAW/WAW hazard scoreboard with per-register latency countdowns.
// Define SCOREBOARD_FORWARD_EN to let sources issue one cycle before writeback.
module dual_issue_scoreboard #(
  parameter int NUM_REGS = 128,
  parameter int LAT_W    = 3,
  parameter int STALL_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_flush,
  dual_issue_scoreboard_if.slave ifc,
  output logic [7:0]           o_busyCount,
  output logic [STALL_W-1:0]   o_stallCycles
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

  logic [LAT_W-1:0]   r_cnt [NUM_REGS];
  logic [LAT_W-1:0]   w_cntNext [NUM_REGS];
  logic [7:0]         r_busyCount;
  logic [7:0]         w_busyNext;
  logic [STALL_W-1:0] r_stallCycles;

  logic [LAT_W-1:0] w_lat1;
  logic [LAT_W-1:0] w_lat2;
  logic             w_src1;
  logic             w_src2;
  logic             w_waw1;
  logic             w_waw2;
  logic             w_intra;
  logic             w_issue1;
  logic             w_issue2;
  logic             w_stall;

  function automatic logic srcReady(input logic [LAT_W-1:0] c);
`ifdef SCOREBOARD_FORWARD_EN
    return c <= LAT_ONE;
`else
    return c == '0;
`endif
  endfunction

  // A zero latency would never satisfy the WAW compare, so it is promoted to one cycle.
  assign w_lat1 = (ifc.lat_1 == '0) ? LAT_ONE : ifc.lat_1;
  assign w_lat2 = (ifc.lat_2 == '0) ? LAT_ONE : ifc.lat_2;

  assign w_src1 = (~ifc.useRA_1 | srcReady(r_cnt[ifc.ra_1]))
                & (~ifc.useRB_1 | srcReady(r_cnt[ifc.rb_1]))
                & (~ifc.useRC_1 | srcReady(r_cnt[ifc.rc_1]));
  assign w_src2 = (~ifc.useRA_2 | srcReady(r_cnt[ifc.ra_2]))
                & (~ifc.useRB_2 | srcReady(r_cnt[ifc.rb_2]))
                & (~ifc.useRC_2 | srcReady(r_cnt[ifc.rc_2]));

  assign w_waw1 = ~ifc.writesRT_1 | (r_cnt[ifc.rt_1] < w_lat1);
  assign w_waw2 = ~ifc.writesRT_2 | (r_cnt[ifc.rt_2] < w_lat2);

  // Slot 2 may not consume or overwrite slot 1's destination in the same pair.
  assign w_intra = ifc.valid_1 & ifc.writesRT_1 &
                   ((ifc.useRA_2 & (ifc.ra_2 == ifc.rt_1)) |
                    (ifc.useRB_2 & (ifc.rb_2 == ifc.rt_1)) |
                    (ifc.useRC_2 & (ifc.rc_2 == ifc.rt_1)) |
                    (ifc.writesRT_2 & (ifc.rt_2 == ifc.rt_1)));

  assign w_issue1 = ~i_flush & ifc.valid_1 & w_src1 & w_waw1;
  assign w_issue2 = ~i_flush & ifc.valid_2 & (w_issue1 | ~ifc.valid_1)
                  & w_src2 & w_waw2 & ~w_intra;
  assign w_stall  = (ifc.valid_1 & ~w_issue1) | (ifc.valid_2 & ~w_issue2);

  assign ifc.issue_1 = w_issue1;
  assign ifc.issue_2 = w_issue2;
  assign ifc.stall   = w_stall;

  always_comb begin
    w_busyNext = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_cntNext[r] = (i_flush || r_cnt[r] == '0) ? '0 : r_cnt[r] - LAT_ONE;
      if (w_issue1 && ifc.writesRT_1 && ifc.rt_1 == IDX_W'(r)) begin
        w_cntNext[r] = w_lat1;
      end
      if (w_issue2 && ifc.writesRT_2 && ifc.rt_2 == IDX_W'(r)) begin
        w_cntNext[r] = w_lat2;
      end
      w_busyNext = w_busyNext + {7'd0, (w_cntNext[r] != '0)};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= '0;
      end
      r_busyCount   <= '0;
      r_stallCycles <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= w_cntNext[r];
      end
      r_busyCount <= w_busyNext;
      if (w_stall && !i_flush && r_stallCycles != '1) begin
        r_stallCycles <= r_stallCycles + STALL_W'(1);
      end
    end
  end

  assign o_busyCount   = r_busyCount;
  assign o_stallCycles = r_stallCycles;

endmodule
